ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes such as LED set (0xED) and enable (0xF4) to the keyboard over the same open-drain SCL/SDA pair that the PS/2 receiver monitors. It runs the full host request sequence: clock inhibit, start bit, data, odd parity, stop and device ACK. It reports completion or error to the controlling logic.

Parameters:
DP_size, 8, data pack size in bits
INHIBIT_CYC, 5000, CLOCK cycles SCL is held low before the request (100 us at 50 MHz)
TIMEOUT_CYC, 750000, CLOCK cycles allowed from SCL release to ACK (15 ms at 50 MHz); used only with the optional feature

Ports:
CLOCK  input  1  system clock; single clock domain
RESET  input  1  asynchronous, active-low reset
TX_DATA  input  DP_size  byte to send; sampled when TX_START is accepted
TX_START  input  1  one-cycle request; ignored while TX_BUSY=1
TX_BUSY  output  1  high from accept until return to IDLE
TX_DONE  output  1  one-cycle pulse: frame sent and ACK received
TX_ERROR  output  1  one-cycle pulse: ACK missing or timeout
SCL_IN  input  1  PS/2 clock line level (asynchronous)
SDA_IN  input  1  PS/2 data line level (asynchronous)
SCL_OE  output  1  1 = drive SCL low; 0 = release
SDA_OE  output  1  1 = drive SDA low; 0 = release

Behaviour:
- Reset (RESET=0, asynchronous):
  - State IDLE; all outputs 0, so both lines are released.
  - Counters and shift register cleared.
  - Asserting reset mid-frame releases the lines immediately.
- Input synchronisation:
  - SCL_IN and SDA_IN each pass through a 2-flop synchroniser.
  - A falling edge is sync'd SCL going 1 -> 0 between consecutive cycles.
- Frame:
  - Shift register holds {stop=1, parity, TX_DATA}.
  - Parity = ~^TX_DATA (odd parity).
- States:
  - IDLE: TX_START=1 latches TX_DATA, sets TX_BUSY=1 next cycle, and goes to INHIBIT.
  - INHIBIT: SCL_OE=1, SDA_OE=0 for INHIBIT_CYC cycles. Then SDA_OE=1 (start bit) for one cycle, then go to REQUEST.
  - REQUEST: SCL_OE=0, SDA_OE=1, bit_cnt=0. Wait for a falling edge.
  - DATA:
    - On each falling edge, put the next frame bit on SDA: SDA_OE = ~bit.
    - Edges 1-8 carry data LSB first, edge 9 carries parity, edge 10 carries stop (SDA_OE=0).
    - SDA_OE must update within 3 CLOCK cycles of the SCL_IN fall. The device samples on the rising edge.
    - bit_cnt increments per edge.
  - ACK:
    - On the 11th falling edge, sample sync'd SDA. 0 = ACK ok; 1 = failure.
    - Go to WAIT_IDLE either way, carrying the ok/failure result.
  - WAIT_IDLE: wait until sync'd SCL=1 and SDA=1. Then pulse TX_DONE (ACK ok) or TX_ERROR (failure), drop TX_BUSY the same cycle, and go to IDLE.
- TX_DONE and TX_ERROR are mutually exclusive and exactly one cycle wide.
- TX_START is ignored while busy; TX_DATA changes after acceptance have no effect.
- TX_START arriving on the cycle TX_BUSY falls is ignored; a new transfer needs TX_START while in IDLE.
- SDA_OE is never 1 while in IDLE or WAIT_IDLE.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined:
  - A watchdog counter starts when SCL is released (entry to REQUEST) and runs through WAIT_IDLE.
  - Reaching TIMEOUT_CYC releases both lines, pulses TX_ERROR, clears TX_BUSY and returns to IDLE.
  - The counter clears in IDLE.
- Not defined:
  - No watchdog is built. A silent device leaves the block in REQUEST indefinitely; only RESET recovers.

Test Plan:
- Send 0xED (INHIBIT_CYC=20, device model clocks at 10 kHz, ACKs) -> SCL_OE high 20 cycles; SDA bits after start = 1,0,1,1,0,1,1,1, parity 1, stop released; TX_DONE one pulse; TX_BUSY falls the same cycle.
- Send 0xF4 and 0x00 -> data bits LSB first; parity 0 for 0xF4, 1 for 0x00; device model reports correct parity; TX_DONE.
- Device model does not pull SDA low on the 11th clock -> TX_ERROR pulses once; TX_DONE stays 0; lines released.
- TX_START with 0x55 while busy sending 0xED -> ignored; only 0xED appears on the wire; exactly one TX_DONE.
- RESET low during bit 4 -> SCL_OE=SDA_OE=0 and TX_BUSY=0 immediately; after release, a new 0xF4 transfer completes normally.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYC=1000, device never clocks -> TX_ERROR at 1000 cycles after REQUEST entry, then IDLE; without the macro -> stays busy in REQUEST.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, LSB-first data, odd parity, stop, ACK.
// Define PS2_TX_TIMEOUT_EN to build the watchdog that runs from SCL release to completion.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int DP_size     = 8,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [DP_size-1:0] TX_DATA,
  input  logic               TX_START,
  output logic               TX_BUSY,
  output logic               TX_DONE,
  output logic               TX_ERROR,
  input  logic               SCL_IN,
  input  logic               SDA_IN,
  output logic               SCL_OE,
  output logic               SDA_OE
);
  localparam int CW = $clog2(INHIBIT_CYC + 1);
  localparam int BW = $clog2(DP_size + 3);
  localparam int FW = DP_size + 2;

  typedef enum logic [2:0] {IDLE, INHIBIT, START, REQUEST, DATA, WAIT_IDLE} state_t;
  state_t state, state_n;

  logic [2:0]    scl_sync;
  logic [1:0]    sda_sync;
  logic          scl_s, sda_s, scl_fall;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] frame;
  logic          sda_oe, ack_ok, done, err;
  logic          wd_hit;

  // Sync flops reset high so a released bus never looks like an edge.
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[1:0], SCL_IN};
      sda_sync <= {sda_sync[0], SDA_IN};
    end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_fall = scl_sync[2] & ~scl_sync[1];

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd;
  logic          wd_run;
  assign wd_run = (state == REQUEST) || (state == DATA) || (state == WAIT_IDLE);
  assign wd_hit = wd_run && (wd == WW'(TIMEOUT_CYC - 1));
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET)      wd <= '0;
    else if (wd_run) wd <= wd + 1'b1;
    else             wd <= '0;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    TX_BUSY = (state != IDLE);
    SCL_OE  = (state == INHIBIT) || (state == START);
    case (state)
      IDLE:      if (TX_START) state_n = INHIBIT;
      INHIBIT:   if (cnt == CW'(INHIBIT_CYC - 1)) state_n = START;
      START:     state_n = REQUEST;
      REQUEST:   if (scl_fall) state_n = DATA;
      DATA:      if (scl_fall && bit_cnt == BW'(DP_size + 2)) state_n = WAIT_IDLE;
      WAIT_IDLE: if (scl_s && sda_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (wd_hit) state_n = IDLE;
  end

  // Frame shifts out LSB first; the stop bit (1) leaves SDA released.
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      cnt     <= '0;
      bit_cnt <= '0;
      frame   <= '0;
      sda_oe  <= 1'b0;
      ack_ok  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          sda_oe <= 1'b0;
          if (TX_START) begin
            frame   <= {1'b1, ~^TX_DATA, TX_DATA};
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (state_n == START) sda_oe <= 1'b1;
        end
        START: bit_cnt <= '0;
        REQUEST: if (scl_fall) begin
          sda_oe  <= ~frame[0];
          frame   <= frame >> 1;
          bit_cnt <= BW'(1);
        end
        DATA: if (scl_fall) begin
          if (bit_cnt == BW'(DP_size + 2)) begin
            ack_ok <= ~sda_s;
            sda_oe <= 1'b0;
          end else begin
            sda_oe  <= ~frame[0];
            frame   <= frame >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          sda_oe <= 1'b0;
          if (scl_s && sda_s) begin
            done <= ack_ok;
            err  <= ~ack_ok;
          end
        end
        default: sda_oe <= 1'b0;
      endcase
      if (wd_hit) begin
        sda_oe <= 1'b0;
        done   <= 1'b0;
        err    <= 1'b1;
      end
    end

  assign SDA_OE   = sda_oe;
  assign TX_DONE  = done;
  assign TX_ERROR = err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames and reports what it received.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int DP  = 8;
  localparam int INH = 20;
  localparam int TO  = 1000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DP-1:0] tx_data = '0;
  logic          tx_start = 1'b0;
  logic          tx_busy, tx_done, tx_error, scl_oe, sda_oe;
  logic          dev_scl_low = 1'b0, dev_sda_low = 1'b0;
  logic          scl_line, sda_line;

  assign scl_line = ~(scl_oe | dev_scl_low);
  assign sda_line = ~(sda_oe | dev_sda_low);

  ps2_host_tx #(.DP_size(DP), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .CLOCK(clk), .RESET(rst_n), .TX_DATA(tx_data), .TX_START(tx_start),
    .TX_BUSY(tx_busy), .TX_DONE(tx_done), .TX_ERROR(tx_error),
    .SCL_IN(scl_line), .SDA_IN(sda_line), .SCL_OE(scl_oe), .SDA_OE(sda_oe)
  );

  always #10 clk = ~clk;

  typedef struct { logic [DP-1:0] data; bit ack; bit timeout; } exp_t;
  typedef struct { logic [DP-1:0] data; logic par; logic stop; } rx_t;
  exp_t exp_q[$];
  rx_t  rx_q[$];
  exp_t mon_e;
  rx_t  mon_r;

  int tests = 0, fails = 0;
  int cyc = 0, dev_bits = 0, inh_cnt = 0;
  bit dev_abort = 0, sda_idle_bad = 0, prev_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      inh_cnt    <= 0;
      prev_pulse <= 1'b0;
    end else begin
      if (!tx_busy && sda_oe) sda_idle_bad <= 1'b1;
      if (scl_oe && !sda_oe) inh_cnt <= inh_cnt + 1;
      else begin
        if (scl_oe && sda_oe && inh_cnt != 0) check("inhibit_len", inh_cnt, INH);
        inh_cnt <= 0;
      end
      if (prev_pulse) check("pulse_one_cycle", {31'd0, tx_done | tx_error}, 0);
      prev_pulse <= tx_done | tx_error;
      if (tx_done || tx_error) begin
        check("done_err_exclusive", {31'd0, tx_done & tx_error}, 0);
        check("busy_falls_with_pulse", {31'd0, tx_busy}, 0);
        if (exp_q.size() == 0) fail_now("unexpected_completion");
        else begin
          mon_e = exp_q.pop_front();
          check("result_done", {31'd0, tx_done}, {31'd0, mon_e.ack && !mon_e.timeout});
          if (!mon_e.timeout) begin
            if (rx_q.size() == 0) fail_now("device_frame_missing");
            else begin
              mon_r = rx_q.pop_front();
              check("wire_data", {24'd0, mon_r.data}, {24'd0, mon_e.data});
              check("wire_parity", {31'd0, mon_r.par},
                    ($countones(mon_e.data) % 2 == 0) ? 32'd1 : 32'd0);
              check("wire_stop", {31'd0, mon_r.stop}, 1);
            end
          end
        end
      end
    end
  end

  // Device model: waits for the host request, clocks 11 times, samples on rising edges.
  task automatic device(bit ack, int h);
    rx_t r;
    int  n = 0;
    dev_bits = 0;
    while (!(scl_line && !sda_line) && n < 300 && !dev_abort) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail_now("request_seen");
      return;
    end
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_scl_low = 1'b1;
      repeat (h) @(negedge clk);
      if (dev_abort) begin dev_scl_low = 1'b0; return; end
      dev_scl_low = 1'b0;
      if (k <= DP)           r.data[k-1] = sda_line;
      else if (k == DP + 1)  r.par       = sda_line;
      else                   r.stop      = sda_line;
      dev_bits = k;
      repeat (h) @(negedge clk);
      if (dev_abort) return;
    end
    rx_q.push_back(r);
    dev_sda_low = ack;
    repeat (h) @(negedge clk);
    dev_scl_low = 1'b1;
    repeat (h) @(negedge clk);
    dev_scl_low = 1'b0;
    repeat (h) @(negedge clk);
    dev_sda_low = 1'b0;
  endtask

  task automatic issue(logic [DP-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = DP'($urandom);
    check("busy_after_accept", {31'd0, tx_busy}, 1);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (tx_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy) fail_now(name);
    @(negedge clk);
    check("scl_released", {31'd0, scl_oe}, 0);
    check("sda_released", {31'd0, sda_oe}, 0);
  endtask

  task automatic send(logic [DP-1:0] d, bit ack);
    issue(d);
    exp_q.push_back('{data: d, ack: ack, timeout: 1'b0});
    device(ack, $urandom_range(8, 15));
    wait_idle("frame_complete");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, req_cyc;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, tx_busy}, 0);
    check("reset_scl_oe", {31'd0, scl_oe}, 0);
    check("reset_sda_oe", {31'd0, sda_oe}, 0);
    check("reset_done_err", {30'd0, tx_done, tx_error}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xED with a second request while busy that must be ignored
    issue(8'hED);
    exp_q.push_back('{data: 8'hED, ack: 1'b1, timeout: 1'b0});
    @(negedge clk);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    device(1'b1, 10);
    wait_idle("frame_ed");

    send(8'hF4, 1'b1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) send(DP'($urandom), $urandom_range(0, 3) != 0);

    // Reset during bit 4 releases everything at once
    issue(8'hA5);
    exp_q.push_back('{data: 8'hA5, ack: 1'b1, timeout: 1'b0});
    dev_abort = 1'b0;
    fork
      device(1'b1, 12);
      begin
        n = 0;
        while (dev_bits < 4 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (dev_bits < 4) fail_now("reach_bit4");
        rst_n     = 1'b0;
        dev_abort = 1'b1;
        #1;
        check("midreset_scl_oe", {31'd0, scl_oe}, 0);
        check("midreset_sda_oe", {31'd0, sda_oe}, 0);
        check("midreset_busy", {31'd0, tx_busy}, 0);
      end
    join
    dev_scl_low = 1'b0;
    dev_sda_low = 1'b0;
    exp_q.delete();
    rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    dev_abort = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hF4, 1'b1);

    // Silent device
    issue(8'h3C);
    n = 0;
    while (!(!scl_oe && sda_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("request_entry");
    req_cyc = cyc;
`ifdef PS2_TX_TIMEOUT_EN
    exp_q.push_back('{data: 8'h3C, ack: 1'b0, timeout: 1'b1});
    n = 0;
    while (!tx_error && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_error) fail_now("timeout_error");
    else check("timeout_cycles", cyc - req_cyc, TO);
    wait_idle("timeout_idle");
`else
    repeat (TO + 200) @(negedge clk);
    check("silent_busy", {31'd0, tx_busy}, 1);
    check("silent_scl_rel", {31'd0, scl_oe}, 0);
    check("silent_sda_start", {31'd0, sda_oe}, 1);
    check("silent_no_error", {31'd0, tx_error}, 0);
    rst_n = 1'b0;
    #1;
    check("silent_reset_busy", {31'd0, tx_busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif
    repeat (5) @(negedge clk);
    check("sda_never_in_idle", {31'd0, sda_idle_bad}, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("device_frames_drained", rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
